// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low common-anode patterns; bit 7 (DP) is replaced per digit.
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic int log2_pow2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Data/control inputs and display pin outputs of the segment scanner.
interface seg_scan_driver_if #(
  parameter int N_DIGITS = 8,
  parameter int BRIGHT_W = 4
);
  logic [4*N_DIGITS-1:0] data;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   digit_en;
  logic [BRIGHT_W-1:0]   bright;
  logic                  lz_en;
  logic                  load;
  logic                  update_pending;
  logic [7:0]            segments;
  logic [N_DIGITS-1:0]   anodes;
  logic                  frame_start;

  modport master (
    output data, dp, digit_en, bright, lz_en, load,
    input  update_pending, segments, anodes, frame_start
  );

  modport slave (
    input  data, dp, digit_en, bright, lz_en, load,
    output update_pending, segments, anodes, frame_start
  );
endinterface

// File: rtl/seg_scan_timer.sv
// Slot counter and digit index for the scanner; slot/frame boundary flags.
module seg_scan_timer #(
  parameter  int N_DIGITS = 8,
  parameter  int SCAN_DIV = 8192,
  localparam int CNT_W    = $clog2(SCAN_DIV),
  localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             slot_end_o,
  output logic             frame_end_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_end;
  logic             frame_end;

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign idx_o       = idx_q;
  assign slot_end_o  = slot_end;
  assign frame_end_o = frame_end;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-aligned updates,
// leading-zero blanking and PWM brightness.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 8192,
  parameter int BRIGHT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_driver_if.slave   bus
);

  localparam int CNT_W = log2_pow2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             slot_end;
  logic             frame_end;

  seg_scan_timer #(
    .N_DIGITS (N_DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .cnt_o       (cnt),
    .idx_o       (idx),
    .slot_end_o  (slot_end),
    .frame_end_o (frame_end)
  );

  logic [4*N_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [N_DIGITS-1:0]   pend_dp_q,   pend_dp_d;
  logic [N_DIGITS-1:0]   pend_en_q,   pend_en_d;
  logic [4*N_DIGITS-1:0] act_data_q,  act_data_d;
  logic [N_DIGITS-1:0]   act_dp_q,    act_dp_d;
  logic [N_DIGITS-1:0]   act_en_q,    act_en_d;
  logic                  upd_q,       upd_d;
  logic [7:0]            seg_q,       seg_d;
  logic [N_DIGITS-1:0]   an_q,        an_d;
  logic                  fs_q,        fs_d;
  logic                  slot_end_q;

  // A load coinciding with frame_end bypasses pending; pending still tracks it
  // so the next frame boundary does not revert to stale data.
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    upd_d       = upd_q;
    if (bus.load) begin
      pend_data_d = bus.data;
      pend_dp_d   = bus.dp;
      pend_en_d   = bus.digit_en;
      upd_d       = 1'b1;
    end
    if (frame_end) begin
      act_data_d = bus.load ? bus.data     : pend_data_q;
      act_dp_d   = bus.load ? bus.dp       : pend_dp_q;
      act_en_d   = bus.load ? bus.digit_en : pend_en_q;
      upd_d      = 1'b0;
    end
  end

  logic [N_DIGITS-1:0] lz_mask;
  logic                zero_run;

  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (act_data_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
      lz_mask[i] = zero_run;
    end
  end

  logic [3:0]          nib;
  logic [7:0]          pattern;
  logic [BRIGHT_W-1:0] pwm_phase;
  logic                pwm_on;
  logic                blank;

  always_comb begin
    nib       = act_data_q[{idx, 2'b00} +: 4];
    pattern   = {~act_dp_q[idx], HEX_SEG[nib][6:0]};
    pwm_phase = cnt[CNT_W-1 -: BRIGHT_W];
    pwm_on    = (pwm_phase < bus.bright) || (&bus.bright);
    blank     = !act_en_q[idx]
             || (bus.lz_en && (idx != '0) && lz_mask[idx])
             || !pwm_on;
    seg_d     = blank ? SEG_OFF : pattern;
    an_d      = blank ? '1 : ~(AN_ONE << idx);
    // Start of digit 0 is only reached through a slot wrap, never via reset.
    fs_d      = slot_end_q && (idx == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '0;
      upd_q       <= 1'b0;
      seg_q       <= SEG_OFF;
      an_q        <= '1;
      fs_q        <= 1'b0;
      slot_end_q  <= 1'b0;
    end else begin
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_en_q    <= act_en_d;
      upd_q       <= upd_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      fs_q        <= fs_d;
      slot_end_q  <= slot_end;
    end
  end

  assign bus.update_pending = upd_q;
  assign bus.segments       = seg_q;
  assign bus.anodes         = an_q;
  assign bus.frame_start    = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 8 digits, 16-cycle slots, 4-bit brightness.
module tb_seg_scan_driver;
  localparam int ND = 8;
  localparam int SD = 16;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] exp_an  [ND];
  logic [7:0] exp_seg [ND];

  seg_scan_driver_if #(.N_DIGITS(ND), .BRIGHT_W(BW)) bus ();

  seg_scan_driver #(.N_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    bus.data     = d;
    bus.dp       = p;
    bus.digit_en = e;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic wait_fs(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.frame_start !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("frame_start_wait", 32'(bus.frame_start), 32'd1);
  endtask

  // Called at the frame_start sample; checks each digit at cnt 0 of its slot.
  task automatic check_frame(input string tag);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("%s_an%0d", tag, i),  32'(bus.anodes),   32'(exp_an[i]));
      chk($sformatf("%s_seg%0d", tag, i), 32'(bus.segments), 32'(exp_seg[i]));
      if (i < ND - 1) repeat (SD) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int lows;
    logic [7:0] and_an;
    logic [7:0] and_seg;

    rst          = 1'b1;
    bus.data     = '0;
    bus.dp       = '0;
    bus.digit_en = '1;
    bus.bright   = 4'hF;
    bus.lz_en    = 1'b0;
    bus.load     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(bus.segments), 32'hFF);
    chk("rst_an",  32'(bus.anodes),   32'hFF);
    chk("rst_upd", 32'(bus.update_pending), 32'd0);
    chk("rst_fs",  32'(bus.frame_start), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("no_fs_after_reset", 32'(bus.frame_start), 32'd0);
    chk("dark_after_reset",  32'(bus.anodes), 32'hFF);
    repeat (4) @(negedge clk);

    // Basic scan of 12345678
    do_load(32'h1234_5678, 8'h00, 8'hFF);
    chk("upd_set", 32'(bus.update_pending), 32'd1);
    wait_fs(300);
    chk("upd_clear", 32'(bus.update_pending), 32'd0);
    exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    exp_seg = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    check_frame("scan");

    // Leading-zero blanking
    bus.lz_en = 1'b1;
    do_load(32'h0000_00A0, 8'h00, 8'hFF);
    wait_fs(300);
    exp_an  = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_seg = '{8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_frame("lz");

    do_load(32'h0000_00A0, 8'h20, 8'hFF);
    wait_fs(300);
    exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
    exp_seg = '{8'hC0, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'hFF, 8'hFF};
    check_frame("lzdp");

    // Mid-frame load stays hidden until the frame boundary
    wait_fs(300);
    repeat (3 * SD) @(negedge clk);
    do_load(32'hFFFF_FFFF, 8'h00, 8'hFF);
    chk("mid_upd_set", 32'(bus.update_pending), 32'd1);
    repeat (SD - 1) @(negedge clk);
    for (int i = 4; i < ND; i++) begin
      chk($sformatf("old_an%0d", i),  32'(bus.anodes),   32'(exp_an[i]));
      chk($sformatf("old_seg%0d", i), 32'(bus.segments), 32'(exp_seg[i]));
      repeat (SD) @(negedge clk);
    end
    chk("mid_fs",       32'(bus.frame_start), 32'd1);
    chk("mid_upd_clear", 32'(bus.update_pending), 32'd0);
    exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    exp_seg = '{8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E};
    check_frame("all_f");

    // Load landing on the frame_end cycle applies immediately
    wait_fs(300);
    repeat (ND * SD - 2) @(negedge clk);
    do_load(32'h0000_0005, 8'h00, 8'hFF);
    chk("fe_upd_low", 32'(bus.update_pending), 32'd0);
    @(negedge clk);
    chk("fe_fs",     32'(bus.frame_start), 32'd1);
    chk("fe_an0",    32'(bus.anodes), 32'hFE);
    chk("fe_seg0",   32'(bus.segments), 32'h92);
    chk("fe_upd_low2", 32'(bus.update_pending), 32'd0);
    repeat (SD) @(negedge clk);
    chk("fe_lz_an1",  32'(bus.anodes), 32'hFF);
    chk("fe_lz_seg1", 32'(bus.segments), 32'hFF);

    // PWM at bright=4: lit for cnt 0..3 only
    bus.bright = 4'h4;
    wait_fs(300);
    lows = 0;
    for (int c = 0; c < SD; c++) begin
      chk($sformatf("pwm4_an_c%0d", c),  32'(bus.anodes),   (c < 4) ? 32'hFE : 32'hFF);
      chk($sformatf("pwm4_seg_c%0d", c), 32'(bus.segments), (c < 4) ? 32'h92 : 32'hFF);
      if (bus.anodes == 8'hFE) lows++;
      @(negedge clk);
    end
    chk("pwm4_low_count", 32'(lows), 32'd4);

    bus.bright = 4'h0;
    wait_fs(300);
    and_an  = 8'hFF;
    and_seg = 8'hFF;
    for (int c = 0; c < ND * SD; c++) begin
      and_an  = and_an & bus.anodes;
      and_seg = and_seg & bus.segments;
      @(negedge clk);
    end
    chk("pwm0_an_dark",  32'(and_an),  32'hFF);
    chk("pwm0_seg_dark", 32'(and_seg), 32'hFF);

    bus.bright = 4'hF;
    wait_fs(300);
    lows = 0;
    for (int c = 0; c < SD; c++) begin
      if (bus.anodes == 8'hFE) lows++;
      @(negedge clk);
    end
    chk("pwmF_low_count", 32'(lows), 32'd16);

    // Reset mid-scan with a pending update
    do_load(32'h1234_5678, 8'h00, 8'hFF);
    chk("pre_rst_upd", 32'(bus.update_pending), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_seg", 32'(bus.segments), 32'hFF);
    chk("mrst_an",  32'(bus.anodes), 32'hFF);
    chk("mrst_upd", 32'(bus.update_pending), 32'd0);
    chk("mrst_fs",  32'(bus.frame_start), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    n = 1;
    chk("mrst_dark", 32'(bus.anodes), 32'hFF);
    while (bus.frame_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("mrst_first_fs_delay", 32'(n), 32'd129);
    chk("mrst_pending_dropped", 32'(bus.anodes), 32'hFF);
    do_load(32'h1234_5678, 8'h00, 8'hFF);
    wait_fs(300);
    chk("mrst_reload_an0",  32'(bus.anodes), 32'hFE);
    chk("mrst_reload_seg0", 32'(bus.segments), 32'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised time-multiplexed driver for common-anode 7-segment displays. It is the next generation of the team's 8-digit hex scanner. It adds:
- configurable digit count
- per-digit decimal point and enable
- leading-zero blanking
- PWM brightness
- tear-free display updates, with new data applied only at frame boundaries

It sits between any status/readout logic and the board's segment/anode pins.

## Interface
Parameters:
- N_DIGITS, 8, number of multiplexed digits, 1..16
- SCAN_DIV, 8192, clocks per digit slot; power of two, ≥ 2**BRIGHT_W
- BRIGHT_W, 4, brightness control width, 1..8

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- data  in  4*N_DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is least significant and rightmost
- dp  in  N_DIGITS  decimal point request per digit
- digit_en  in  N_DIGITS  per-digit enable; 0 blanks that digit
- bright  in  BRIGHT_W  brightness level, sampled live (not shadowed)
- lz_en  in  1  leading-zero blanking enable, sampled live
- load  in  1  one-cycle strobe; captures data/dp/digit_en into the pending registers
- update_pending  out  1  high while a captured update waits for a frame boundary
- segments  out  8  active-low; [6:0] = g..a, [7] = DP
- anodes  out  N_DIGITS  active-low digit select
- frame_start  out  1  one-cycle pulse on the first output cycle of digit 0

## Operation
Scan timer:
- cnt runs 0..SCAN_DIV-1 and wraps.
- slot_end = (cnt == SCAN_DIV-1).
- idx runs 0..N_DIGITS-1 and advances on slot_end, wrapping to 0.
- frame_end = slot_end && idx == N_DIGITS-1.

Update registers:
- load captures the inputs into pending and sets update_pending. A second load while pending overwrites pending; the last value wins.
- On frame_end, active ← pending and update_pending clears.
- load on the frame_end cycle: the strobed inputs go directly into active and update_pending stays 0.

Digit pattern for slot idx, from the active registers:
- Nibble lookup from the hex table: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, B→83, C→C6, D→A1, E→86, F→8E.
- Bit 7 is then set to ~dp[idx].

Blanking (digit anode off, segments = FF) applies when any of these hold:
- digit_en[idx] == 0.
- lz_en == 1, idx ≠ 0, and every digit j ≥ idx has nibble 0 and dp[j] == 0.
- The PWM is off (below).

PWM:
- p = cnt[log2(SCAN_DIV)-1 -: BRIGHT_W].
- On iff p < bright, or bright is all ones (fully on).
- bright == 0 keeps the display dark.

Otherwise anodes = ~(1 << idx), and segments = the pattern.

## Timing
- Reset: cnt = 0, idx = 0, active = 0, pending = 0, update_pending = 0, segments = FF, anodes = all ones, frame_start = 0.
- segments, anodes and frame_start are registered and show the state of cnt/idx from the previous cycle, giving 1-cycle latency.
- The first lit output occurs no earlier than the cycle after rst deasserts.
- frame_start pulses in the output cycle corresponding to idx = 0, cnt = 0. The first pulse comes one frame after reset, since reset itself does not pulse.
- A full frame lasts N_DIGITS*SCAN_DIV cycles.
- A load is visible on the outputs at most one frame plus 1 cycle later.
- update_pending rises the cycle after load and falls the cycle after frame_end.
- rst mid-frame discards pending and active data immediately, and outputs return to their reset values on the next edge.
- With N_DIGITS = 1, idx stays at 0 and frame_end = slot_end.

## Structure
- Package seg_pkg holds:
  - the 16-entry hex→segment constant table
  - SEG_OFF = 8'hFF
  - a function computing log2(SCAN_DIV) for the PWM slice
- Sub-module seg_scan_timer (parameters N_DIGITS, SCAN_DIV) provides cnt, idx, slot_end and frame_end.
- The top module holds the pending/active registers, the blanking and PWM logic, and the output registers.

## Test plan
Default bench parameters: N_DIGITS = 8, SCAN_DIV = 16, BRIGHT_W = 4.
- Reset, then load data=32'h12345678 with dp=0, digit_en=FF, bright=F: after the next frame_start, anodes step FE→FD→…→7F every 16 cycles while segments step 80,F8,82,92,99,B0,A4,F9.
- lz_en=1, data=32'h0000_00A0: digits 7..2 have anode off and segments=FF; digit 1 shows 88 and digit 0 shows C0. Setting dp[5]=1 unblanks digits 5..2, which show 40 (digit 5) and C0.
- bright=4: in each 16-cycle slot the anode is low for exactly 4 cycles, at cnt 0..3. bright=0 keeps all anodes high; bright=F keeps the selected anode low all 16 cycles.
- Load 32'hFFFF_FFFF mid-frame: update_pending=1, and the remaining digits of the current frame still show the old data. After frame_end, all digits show 8E and update_pending=0. A load on the frame_end cycle applies immediately with update_pending staying 0.
- Assert rst for 1 cycle mid-scan: on the next edge segments=FF, anodes=FF and update_pending=0. The scan restarts at digit 0, and data reads as 0 until the next load plus frame boundary.
